// File: rtl/flash_read_arbiter.sv
// rtl/flash_read_arbiter.sv - two-client round-robin SPI NOR READ (0x03) engine
// Optional FLASH_WAKE_EN: send a 0xAB release-power-down frame after reset before serving reads.
module flash_read_arbiter #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_HALVES = 4,
  parameter int WAKE_WAIT  = 64
) (
  input  logic        top_clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [3:0]  len0,
  input  logic [3:0]  len1,
  output logic [1:0]  gnt,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [1:0]  done,
  output logic        busy,
  output logic        cs,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [3:0] {
    IDLE, ARB, CMD, ADDR, DATA, GAP, WAKE, WAKE_TX, WAKE_HOLD
  } state_t;

  state_t       state;
  logic [8:0]   div_cnt;
  logic [7:0]   bit_cnt;
  logic [31:0]  tx_sr;
  logic [6:0]   rx_sr;
  logic [3:0]   len_q;
  logic         owner;
  logic         rr_last;
  logic [15:0]  wait_cnt;
  logic         win;
  logic         rise_tick;
  logic         bit_tick;

  // With both requesting, the one not served last wins.
  assign win       = (req == 2'b11) ? ~rr_last : req[1];
  assign rise_tick = (div_cnt == 9'(CLK_DIV - 1));
  assign bit_tick  = (div_cnt == 9'(2 * CLK_DIV - 1));

  always_ff @(posedge top_clk) begin
    if (rst) begin
`ifdef FLASH_WAKE_EN
      state <= WAKE;
`else
      state <= IDLE;
`endif
      cs       <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      gnt      <= 2'b00;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      done     <= 2'b00;
      busy     <= 1'b0;
      rr_last  <= 1'b1;
      owner    <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sr    <= {8'hAB, 24'h000000};
      rx_sr    <= '0;
      len_q    <= '0;
      wait_cnt <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 2'b00;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner <= win;
            gnt   <= win ? 2'b10 : 2'b01;
            tx_sr <= {8'h03, win ? addr1 : addr0};
            len_q <= win ? len1 : len0;
            busy  <= 1'b1;
            state <= ARB;
          end
        end
        ARB, WAKE: begin
          busy    <= 1'b1;
          cs      <= 1'b0;
          mosi    <= tx_sr[31];
          tx_sr   <= {tx_sr[30:0], 1'b0};
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= (state == ARB) ? CMD : WAKE_TX;
        end
        CMD, ADDR, DATA, WAKE_TX: begin
          div_cnt <= bit_tick ? 9'd0 : div_cnt + 9'd1;
          if (rise_tick) begin
            sck <= 1'b1;
            if (state == DATA) begin
              rx_sr <= {rx_sr[5:0], miso};
              if (bit_cnt[2:0] == 3'd7) begin
                rd_data  <= {rx_sr, miso};
                rd_valid <= 1'b1;
              end
            end
          end
          if (bit_tick) begin
            sck     <= 1'b0;
            bit_cnt <= bit_cnt + 8'd1;
            mosi    <= tx_sr[31];
            tx_sr   <= {tx_sr[30:0], 1'b0};
            if (state == CMD && bit_cnt == 8'd7) begin
              state   <= ADDR;
              bit_cnt <= '0;
            end else if (state == ADDR && bit_cnt == 8'd23) begin
              state   <= DATA;
              bit_cnt <= '0;
              mosi    <= 1'b0;
            end else if (state == DATA) begin
              mosi <= 1'b0;
              if (bit_cnt == {1'b0, len_q, 3'b111}) begin
                state    <= GAP;
                cs       <= 1'b1;
                done     <= gnt;
                gnt      <= 2'b00;
                rr_last  <= owner;
                wait_cnt <= '0;
              end
            end else if (state == WAKE_TX && bit_cnt == 8'd7) begin
              state    <= WAKE_HOLD;
              cs       <= 1'b1;
              mosi     <= 1'b0;
              wait_cnt <= '0;
            end
          end
        end
        GAP: begin
          if (wait_cnt == 16'(GAP_HALVES * CLK_DIV - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        WAKE_HOLD: begin
          if (wait_cnt == 16'(WAKE_WAIT - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb/tb_flash_read_arbiter.sv - scoreboard bench for flash_read_arbiter with a SPI NOR read model
module tb_flash_read_arbiter;

  logic        top_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [3:0]  len0 = '0, len1 = '0;
  logic [1:0]  gnt, done;
  logic [7:0]  rd_data;
  logic        rd_valid, busy, cs, sck, mosi;
  logic        miso = 1'b0;

  flash_read_arbiter #(.CLK_DIV(4), .GAP_HALVES(4), .WAKE_WAIT(64)) dut (
    .top_clk(top_clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1), .gnt(gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .busy(busy), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso)
  );

  always #5 top_clk = ~top_clk;

  typedef struct { int nbits; logic [7:0] cmd; logic [23:0] addr; } frame_t;
  typedef struct { logic [7:0] data; logic [1:0] owner; } byte_t;

  frame_t     exp_frame[$];
  byte_t      exp_data[$];
  logic [1:0] exp_done[$];
  logic [1:0] exp_gnt[$];
  logic [7:0] fdata [16];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flash model: captures the command/address header, returns fdata[] after the address.
  int          fcount = 0;
  logic [31:0] hdr = '0;
  logic        mosi_err = 1'b0;
  logic        ignore_frame = 1'b0;
  int          idx;
  frame_t      fexp;

  always @(negedge cs) begin
    fcount = 0; hdr = '0; mosi_err = 1'b0;
  end

  always @(posedge sck) begin
    if (cs === 1'b0) begin
      if (fcount < 32) hdr = {hdr[30:0], mosi};
      else if (mosi !== 1'b0) mosi_err = 1'b1;
      fcount++;
    end
  end

  always @(negedge sck) begin
    if (cs === 1'b0 && fcount >= 32) begin
      idx = fcount - 32;
      miso = fdata[idx / 8][7 - (idx % 8)];
    end
  end

  always @(posedge cs) begin
    if (ignore_frame) begin
      ignore_frame = 1'b0;
    end else if (fcount > 0) begin
      if (exp_frame.size() == 0) begin
        chk("frame_unexpected", fcount, 0);
      end else begin
        fexp = exp_frame.pop_front();
        chk("frame_bits", fcount, fexp.nbits);
        chk("frame_cmd", (fcount >= 32) ? hdr[31:24] : hdr[7:0], fexp.cmd);
        if (fexp.nbits > 8) chk("frame_addr", hdr[23:0], fexp.addr);
        chk("mosi_zero_in_data", mosi_err, 0);
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  logic       prev_cs = 1'b1;
  logic [1:0] prev_gnt = 2'b00;
  int         low_cnt = 0, high_cnt = 0, last_low = 0, last_high = 0;
  byte_t      bexp;
  logic [1:0] dexp, gexp;

  always @(negedge top_clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (exp_data.size() == 0) chk("rd_unexpected", rd_data, 32'hFFFF_FFFF);
        else begin
          bexp = exp_data.pop_front();
          chk("rd_data", rd_data, bexp.data);
          chk("rd_owner", gnt, bexp.owner);
        end
      end
      if (done != 2'b00) begin
        if (exp_done.size() == 0) chk("done_unexpected", done, 0);
        else begin
          dexp = exp_done.pop_front();
          chk("done", done, dexp);
          chk("gnt_clear_at_done", gnt, 0);
        end
      end
      if (gnt != 2'b00 && prev_gnt == 2'b00) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", gnt, 0);
        else begin
          gexp = exp_gnt.pop_front();
          chk("gnt", gnt, gexp);
        end
      end
    end
    if (cs === 1'b0) begin
      if (prev_cs === 1'b1) begin last_high = high_cnt; low_cnt = 0; end
      low_cnt++;
    end else begin
      if (prev_cs === 1'b0) begin last_low = low_cnt; high_cnt = 0; end
      high_cnt++;
    end
    prev_cs  = cs;
    prev_gnt = gnt;
  end

  task automatic push_txn(input logic who, input logic [23:0] a, input logic [3:0] l);
    exp_frame.push_back('{32 + 8 * (int'(l) + 1), 8'h03, a});
    for (int i = 0; i <= int'(l); i++) exp_data.push_back('{fdata[i], who ? 2'b10 : 2'b01});
    exp_done.push_back(who ? 2'b10 : 2'b01);
    exp_gnt.push_back(who ? 2'b10 : 2'b01);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge top_clk);
    rst = 1'b0;
`ifdef FLASH_WAKE_EN
    exp_frame.push_back('{8, 8'hAB, 24'h0});
`endif
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge top_clk); n++; end while (done == 2'b00 && n < 4000);
    chk("done_seen", done != 2'b00, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge top_clk); n++; end while (busy !== 1'b0 && n < 400);
    chk("idle_seen", busy, 0);
  endtask

  task automatic wait_cs_low();
    int n = 0;
    do begin @(negedge top_clk); n++; end while (cs !== 1'b0 && n < 400);
    chk("cs_low_seen", cs, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fdata[i] = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge top_clk);
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    do_reset(1);
    wait_idle();

    // Single byte read by requester 0
    fdata[0] = 8'hA5;
    addr0 = 24'h012345; len0 = 4'd0;
    push_txn(1'b0, 24'h012345, 4'd0);
    req = 2'b01;
    wait_done();
    req = 2'b00;
    wait_idle();
    chk("cs_low_cycles", last_low, (32 + 8) * 2 * 4);
    chk("rd_data_hold", rd_data, 8'hA5);

    // Four-byte burst by requester 1
    for (int i = 0; i < 4; i++) fdata[i] = 8'h10 + 8'(i);
    addr1 = 24'h000100; len1 = 4'd3;
    push_txn(1'b1, 24'h000100, 4'd3);
    req = 2'b10;
    wait_done();
    req = 2'b00;
    wait_idle();
    chk("cs_low_cycles_burst", last_low, (32 + 32) * 2 * 4);

    // Contention straight out of reset, then both again
    fdata[0] = 8'h5A; fdata[1] = 8'hC3;
    addr0 = 24'h000200; len0 = 4'd0;
    addr1 = 24'h000300; len1 = 4'd1;
    for (int r = 0; r < 2; r++) begin
      push_txn(1'b0, 24'h000200, 4'd0);
      push_txn(1'b1, 24'h000300, 4'd1);
      req = 2'b11;
      if (r == 0) do_reset(2);
      wait_done();
      req[0] = 1'b0;
      wait_done();
      req[1] = 1'b0;
      wait_idle();
    end

    // Back-to-back frames with req0 held through done
    fdata[0] = 8'h3C; fdata[1] = 8'h96;
    addr0 = 24'h00ABCD; len0 = 4'd1;
    push_txn(1'b0, 24'h00ABCD, 4'd1);
    push_txn(1'b0, 24'h00ABCD, 4'd1);
    req = 2'b01;
    wait_done();
    wait_cs_low();
    chk("gap_at_least_16", last_high >= 16, 1);
    wait_done();
    req = 2'b00;
    wait_idle();

    // Reset in the middle of the address phase
    addr0 = 24'h777777; len0 = 4'd0;
    exp_gnt.push_back(2'b01);
    ignore_frame = 1'b1;
    req = 2'b01;
    repeat (100) @(negedge top_clk);
    chk("mid_addr_cs_low", cs, 0);
    req = 2'b00;
    rst = 1'b1;
    @(negedge top_clk);
    chk("abort_cs", cs, 1);
    chk("abort_sck", sck, 0);
    chk("abort_gnt", gnt, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
`ifdef FLASH_WAKE_EN
    exp_frame.push_back('{8, 8'hAB, 24'h0});
`endif
    repeat (30) @(negedge top_clk);
    wait_idle();

    fdata[0] = 8'hE1; fdata[1] = 8'h2D; fdata[2] = 8'h78;
    addr0 = 24'h00F00F; len0 = 4'd2;
    push_txn(1'b0, 24'h00F00F, 4'd2);
    req = 2'b01;
    wait_done();
    req = 2'b00;
    wait_idle();
    repeat (5) @(negedge top_clk);

    chk("frames_left", exp_frame.size(), 0);
    chk("bytes_left", exp_data.size(), 0);
    chk("dones_left", exp_done.size(), 0);
    chk("grants_left", exp_gnt.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
